// File: rtl/btn_debounce.sv
// Button conditioner: per-channel two-flop synchroniser, stability-counter debounce,
// pressed-high normalisation and registered one-cycle press/release pulses.
module btn_debounce #(
  parameter int unsigned WIDTH           = 2,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_stable,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  localparam logic [WIDTH-1:0] RELEASED_LVL = {WIDTH{ACTIVE_LOW}};
  localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] smp_c;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] press_q, press_d;
  logic [WIDTH-1:0] release_q, release_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Next-state: synchroniser shift and per-channel stability counter
  always_comb begin
    s1_d      = btn_raw;
    s2_d      = s1_q;
    smp_c     = s2_q ^ RELEASED_LVL;
    stable_d  = stable_q;
    press_d   = '0;
    release_d = '0;
    cnt_d     = cnt_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (smp_c[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i]  = smp_c[i];
        cnt_d[i]     = '0;
        press_d[i]   = smp_c[i];
        release_d[i] = ~smp_c[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Synchronisers reset to the released pin level so reset never looks like a press
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= RELEASED_LVL;
      s2_q      <= RELEASED_LVL;
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_stable    = stable_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: one active-low and one active-high instance,
// DEBOUNCE_CYCLES=4 so every transition lands 6 edges after a clean pin change.
module tb_btn_debounce;

  logic       clk;
  logic       reset_n;
  logic [1:0] raw_al, raw_ah;
  logic [1:0] stb_al, prs_al, rel_al;
  logic [1:0] stb_ah, prs_ah, rel_ah;
  int         checks;
  int         failures;

  btn_debounce #(.WIDTH(2), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut_al (
    .clk(clk), .reset_n(reset_n), .btn_raw(raw_al),
    .btn_stable(stb_al), .press_pulse(prs_al), .release_pulse(rel_al)
  );

  btn_debounce #(.WIDTH(2), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut_ah (
    .clk(clk), .reset_n(reset_n), .btn_raw(raw_ah),
    .btn_stable(stb_ah), .press_pulse(prs_ah), .release_pulse(rel_ah)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit so sampling and driving avoid the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_al(input string tag, input logic [1:0] s, input logic [1:0] p,
                          input logic [1:0] r);
    check({tag, ".stable"},  stb_al, s);
    check({tag, ".press"},   prs_al, p);
    check({tag, ".release"}, rel_al, r);
  endtask

  task automatic check_ah(input string tag, input logic [1:0] s, input logic [1:0] p,
                          input logic [1:0] r);
    check({tag, ".stable"},  stb_ah, s);
    check({tag, ".press"},   prs_ah, p);
    check({tag, ".release"}, rel_ah, r);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    raw_al   = 2'b00;
    raw_ah   = 2'b00;

    // Reset with both active-low buttons held
    tick(3);
    check_al("rst_hold", 2'b00, 2'b00, 2'b00);
    check_ah("rst_hold_ah", 2'b00, 2'b00, 2'b00);
    reset_n = 1'b1;
    tick(5);
    check_al("rst_rel_e5", 2'b00, 2'b00, 2'b00);
    tick(1);
    check_al("rst_rel_e6", 2'b11, 2'b11, 2'b00);
    tick(1);
    check_al("rst_rel_e7", 2'b11, 2'b00, 2'b00);
    check_ah("idle_ah", 2'b00, 2'b00, 2'b00);

    // Release both
    raw_al = 2'b11;
    tick(5);
    check_al("rel_both_e5", 2'b11, 2'b00, 2'b00);
    tick(1);
    check_al("rel_both_e6", 2'b00, 2'b00, 2'b11);
    tick(1);
    check_al("rel_both_e7", 2'b00, 2'b00, 2'b00);

    // Clean press and release on ch0
    raw_al = 2'b10;
    tick(5);
    check_al("ch0_press_e5", 2'b00, 2'b00, 2'b00);
    tick(1);
    check_al("ch0_press_e6", 2'b01, 2'b01, 2'b00);
    tick(1);
    check_al("ch0_press_e7", 2'b01, 2'b00, 2'b00);
    raw_al = 2'b11;
    tick(5);
    check_al("ch0_rel_e5", 2'b01, 2'b00, 2'b00);
    tick(1);
    check_al("ch0_rel_e6", 2'b00, 2'b00, 2'b01);
    tick(1);
    check_al("ch0_rel_e7", 2'b00, 2'b00, 2'b00);

    // Bounce: low 3, high 1, low 3, high -- never reaches the 4th mismatch edge
    raw_al = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_al("bounce_a", 2'b00, 2'b00, 2'b00);
    end
    raw_al = 2'b11;
    tick(1);
    check_al("bounce_b", 2'b00, 2'b00, 2'b00);
    raw_al = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_al("bounce_c", 2'b00, 2'b00, 2'b00);
    end
    raw_al = 2'b11;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check_al("bounce_d", 2'b00, 2'b00, 2'b00);
    end
    raw_al = 2'b10;
    tick(5);
    check_al("hold_e5", 2'b00, 2'b00, 2'b00);
    tick(1);
    check_al("hold_e6", 2'b01, 2'b01, 2'b00);
    tick(1);
    check_al("hold_e7", 2'b01, 2'b00, 2'b00);
    raw_al = 2'b11;
    tick(6);
    check_al("hold_rel_e6", 2'b00, 2'b00, 2'b01);
    tick(1);

    // Simultaneous press on both channels
    raw_al = 2'b00;
    tick(5);
    check_al("simul_e5", 2'b00, 2'b00, 2'b00);
    tick(1);
    check_al("simul_e6", 2'b11, 2'b11, 2'b00);
    tick(1);
    check_al("simul_e7", 2'b11, 2'b00, 2'b00);
    raw_al = 2'b11;
    tick(6);
    check_al("simul_rel_e6", 2'b00, 2'b00, 2'b11);
    tick(1);

    // Ch1 bounces once during ch0's count: ch0 at edge 6, ch1 delayed to edge 9
    raw_al = 2'b00;
    tick(2);
    raw_al = 2'b10;
    tick(1);
    raw_al = 2'b00;
    tick(3);
    check_al("indep_e6", 2'b01, 2'b01, 2'b00);
    tick(1);
    check_al("indep_e7", 2'b01, 2'b00, 2'b00);
    tick(1);
    check_al("indep_e8", 2'b01, 2'b00, 2'b00);
    tick(1);
    check_al("indep_e9", 2'b11, 2'b10, 2'b00);
    tick(1);
    check_al("indep_e10", 2'b11, 2'b00, 2'b00);
    raw_al = 2'b11;
    tick(6);
    check_al("indep_rel_e6", 2'b00, 2'b00, 2'b11);
    tick(1);

    // Reset after two mismatch edges on ch1, button kept pressed
    raw_al = 2'b01;
    tick(4);
    check_al("midrst_pre", 2'b00, 2'b00, 2'b00);
    reset_n = 1'b0;
    #1;
    check_al("midrst_in", 2'b00, 2'b00, 2'b00);
    tick(1);
    reset_n = 1'b1;
    tick(5);
    check_al("midrst_e5", 2'b00, 2'b00, 2'b00);
    tick(1);
    check_al("midrst_e6", 2'b10, 2'b10, 2'b00);
    tick(1);
    check_al("midrst_e7", 2'b10, 2'b00, 2'b00);

    // Active-high instance: no spurious pulse after reset, then press/release ch1
    for (int i = 0; i < 3; i++) begin
      check_ah("ah_idle", 2'b00, 2'b00, 2'b00);
      tick(1);
    end
    raw_ah = 2'b10;
    tick(5);
    check_ah("ah_press_e5", 2'b00, 2'b00, 2'b00);
    tick(1);
    check_ah("ah_press_e6", 2'b10, 2'b10, 2'b00);
    tick(1);
    check_ah("ah_press_e7", 2'b10, 2'b00, 2'b00);
    raw_ah = 2'b00;
    tick(6);
    check_ah("ah_rel_e6", 2'b00, 2'b00, 2'b10);
    tick(1);
    check_ah("ah_rel_e7", 2'b00, 2'b00, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
